// File: rtl/wwm_turn_if.sv
// Handshake and display bundle between the input/debounce logic, the turn controller and the VGA renderer.
interface wwm_turn_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W     = 10,
  parameter int V_W         = 4,
  parameter int SCORE_W     = 4,
  parameter int T_W         = 8
);
  localparam int PW = $clog2(NUM_PLAYERS);

  logic                           Start;
  logic                           Ack;
  logic                           Fire;
  logic                           frame_tick;
  logic [V_W-1:0]                 vX;
  logic [V_W-1:0]                 vY;
  logic                           q_I;
  logic                           q_Shoot;
  logic                           q_Animate;
  logic                           q_Done;
  logic [PW-1:0]                  player;
  logic [COORD_W-1:0]             proj_x;
  logic [COORD_W-1:0]             proj_y;
  logic [T_W-1:0]                 t_air;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic [PW-1:0]                  winner;
  logic                           hit;
  logic                           miss;

  modport master (
    output Start, Ack, Fire, frame_tick, vX, vY,
    input  q_I, q_Shoot, q_Animate, q_Done, player, proj_x, proj_y,
           t_air, scores, winner, hit, miss
  );

  modport slave (
    input  Start, Ack, Fire, frame_tick, vX, vY,
    output q_I, q_Shoot, q_Animate, q_Done, player, proj_x, proj_y,
           t_air, scores, winner, hit, miss
  );
endinterface

// File: rtl/wwm_turn_sm.sv
// World War Math turn controller: per-frame projectile integration, hit/miss
// resolution, turn rotation, scoring and winner detection.
module wwm_turn_sm #(
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W     = 10,
  parameter int V_W         = 4,
  parameter int SCORE_W     = 4,
  parameter int T_W         = 8,
  parameter int T_MAX       = 255,
  parameter int WIN_SCORE   = 3,
  parameter int GRAVITY     = 1,
  parameter int X_INIT_L    = 200,
  parameter int X_INIT_R    = 735,
  parameter int Y_INIT      = 470,
  parameter int X_MIN       = 160,
  parameter int X_MAX       = 775,
  parameter int Y_MIN       = 50,
  parameter int Y_MAX       = 475,
  parameter int TR_XLO      = 650,
  parameter int TR_XHI      = 675,
  parameter int TL_XLO      = 260,
  parameter int TL_XHI      = 285,
  parameter int T_YLO       = 460,
  parameter int T_YHI       = 475
) (
  input logic       clk,
  input logic       Reset_n,
  wwm_turn_if.slave bus
);
  localparam int PW  = $clog2(NUM_PLAYERS);
  localparam int CW  = COORD_W + 2;
  localparam int VYW = V_W + T_W + 1;

  typedef enum logic [1:0] {S_I, S_SHOOT, S_ANIM, S_DONE} state_t;
  typedef logic signed [CW-1:0] crd_t;

  localparam crd_t XMIN_S = crd_t'(X_MIN);
  localparam crd_t XMAX_S = crd_t'(X_MAX);
  localparam crd_t YMIN_S = crd_t'(Y_MIN);
  localparam crd_t YMAX_S = crd_t'(Y_MAX);
  localparam crd_t TYLO_S = crd_t'(T_YLO);
  localparam crd_t TYHI_S = crd_t'(T_YHI);

  state_t                            state_q, state_d;
  logic [PW-1:0]                     player_q, player_d, winner_q, winner_d;
  logic [COORD_W-1:0]                x_q, x_d, y_q, y_d;
  logic [T_W-1:0]                    t_q, t_d;
  logic [V_W-1:0]                    vx_q, vx_d;
  logic signed [VYW-1:0]             vy_q, vy_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] scores_q, scores_d;
  logic                              hit_q, hit_d, miss_q, miss_d;

  crd_t               nx, ny, tlo, thi;
  logic [T_W-1:0]     t_inc;
  logic [SCORE_W-1:0] sc_cur, sc_new;
  logic [PW-1:0]      p_nxt;
  logic [COORD_W-1:0] lx;
  logic               in_tgt, oob;

  // Datapath shared by all states; only consumed on an ANIMATE frame tick.
  always_comb begin
    nx     = player_q[0] ? $signed({2'b00, x_q}) - crd_t'(vx_q)
                         : $signed({2'b00, x_q}) + crd_t'(vx_q);
    ny     = $signed({2'b00, y_q}) - crd_t'(vy_q);
    tlo    = player_q[0] ? crd_t'(TL_XLO) : crd_t'(TR_XLO);
    thi    = player_q[0] ? crd_t'(TL_XHI) : crd_t'(TR_XHI);
    t_inc  = t_q + T_W'(1);
    sc_cur = scores_q[player_q];
    sc_new = (sc_cur == '1) ? sc_cur : sc_cur + SCORE_W'(1);
    p_nxt  = (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + PW'(1);
    lx     = player_q[0] ? COORD_W'(X_INIT_R) : COORD_W'(X_INIT_L);
    in_tgt = (nx >= tlo) && (nx <= thi) && (ny >= TYLO_S) && (ny <= TYHI_S);
    oob    = (nx <= XMIN_S) || (nx >= XMAX_S) || (ny < YMIN_S) || (ny > YMAX_S) ||
             (nx < 0) || (ny < 0) || (t_inc == T_W'(T_MAX));
  end

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    winner_d = winner_q;
    x_d      = x_q;
    y_d      = y_q;
    t_d      = t_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    scores_d = scores_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    case (state_q)
      S_I: if (bus.Start) begin
        state_d  = S_SHOOT;
        scores_d = '0;
        player_d = '0;
      end
      S_SHOOT: begin
        x_d = lx;
        y_d = COORD_W'(Y_INIT);
        t_d = '0;
        if (bus.Fire) begin
          state_d = S_ANIM;
          vx_d    = bus.vX;
          vy_d    = $signed({{(VYW-V_W){1'b0}}, bus.vY});
        end
      end
      S_ANIM: if (bus.frame_tick) begin
        x_d  = nx[COORD_W-1:0];
        y_d  = ny[COORD_W-1:0];
        vy_d = vy_q - $signed(VYW'(GRAVITY));
        t_d  = t_inc;
        // Hit wins over miss when the landing point is both on target and at a bound.
        if (in_tgt) begin
          hit_d              = 1'b1;
          scores_d[player_q] = sc_new;
          if (sc_new == SCORE_W'(WIN_SCORE)) begin
            state_d  = S_DONE;
            winner_d = player_q;
          end else begin
            state_d  = S_SHOOT;
            player_d = p_nxt;
          end
        end else if (oob) begin
          miss_d   = 1'b1;
          state_d  = S_SHOOT;
          player_d = p_nxt;
        end
      end
      S_DONE: if (bus.Ack) state_d = S_I;
      default: state_d = S_I;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_I;
      player_q <= '0;
      winner_q <= '0;
      x_q      <= COORD_W'(X_INIT_L);
      y_q      <= COORD_W'(Y_INIT);
      t_q      <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      scores_q <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      winner_q <= winner_d;
      x_q      <= x_d;
      y_q      <= y_d;
      t_q      <= t_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      scores_q <= scores_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.q_I       = (state_q == S_I);
  assign bus.q_Shoot   = (state_q == S_SHOOT);
  assign bus.q_Animate = (state_q == S_ANIM);
  assign bus.q_Done    = (state_q == S_DONE);
  assign bus.player    = player_q;
  assign bus.winner    = winner_q;
  assign bus.proj_x    = x_q;
  assign bus.proj_y    = y_q;
  assign bus.t_air     = t_q;
  assign bus.scores    = scores_q;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
endmodule

// File: tb/tb_wwm_turn_sm.sv
// Directed bench for wwm_turn_sm: default instance plus a short-timeout (T_MAX=8) instance.
module tb_wwm_turn_sm;
  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wwm_turn_if b0 ();
  wwm_turn_if b1 ();

  wwm_turn_sm dut0 (.clk(clk), .Reset_n(Reset_n), .bus(b0));
  wwm_turn_sm #(.T_MAX(8)) dut1 (.clk(clk), .Reset_n(Reset_n), .bus(b1));

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic tick0();
    b0.frame_tick = 1'b1; cyc(); b0.frame_tick = 1'b0;
  endtask

  // One idle cycle precedes every tick so ANIMATE must hold between frames.
  task automatic ticks0(input int n);
    for (int i = 0; i < n; i++) begin cyc(); tick0(); end
  endtask

  task automatic start0();
    b0.Start = 1'b1; cyc(); b0.Start = 1'b0;
  endtask

  task automatic launch0(input logic [3:0] vx, input logic [3:0] vy);
    b0.vX = vx; b0.vY = vy; b0.Fire = 1'b1; cyc(); b0.Fire = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; cyc(); cyc();
    n_tests++;
    if ({b0.q_I, b0.q_Shoot, b0.q_Animate, b0.q_Done} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_state got %b want 1000", {b0.q_I, b0.q_Shoot, b0.q_Animate, b0.q_Done});
    end
    n_tests++;
    if ({b0.proj_x, b0.proj_y} !== {10'd200, 10'd470}) begin
      n_fail++; $display("FAIL reset_proj got (%0d,%0d) want (200,470)", b0.proj_x, b0.proj_y);
    end
    n_tests++;
    if ({b0.t_air, b0.scores, b0.hit, b0.miss, b0.player, b0.winner} !== 20'd0) begin
      n_fail++; $display("FAIL reset_regs got t=%0d s=%h h=%b m=%b p=%0d w=%0d want zeros",
                         b0.t_air, b0.scores, b0.hit, b0.miss, b0.player, b0.winner);
    end
  endtask

  task automatic test_ignore_in_i();
    Reset_n = 1'b1;
    b0.Fire = 1'b1; b0.Ack = 1'b1; b0.frame_tick = 1'b1;
    cyc(); cyc(); cyc();
    b0.Fire = 1'b0; b0.Ack = 1'b0; b0.frame_tick = 1'b0;
    n_tests++;
    if (b0.q_I !== 1'b1 || b0.proj_x !== 10'd200) begin
      n_fail++; $display("FAIL ignore_in_i got qI=%b x=%0d want qI=1 x=200", b0.q_I, b0.proj_x);
    end
  endtask

  task automatic test_hit_p0();
    start0();
    n_tests++;
    if (b0.q_Shoot !== 1'b1 || b0.player !== 1'b0) begin
      n_fail++; $display("FAIL start got qS=%b p=%0d want qS=1 p=0", b0.q_Shoot, b0.player);
    end
    launch0(4'd15, 4'd15);
    cyc();
    n_tests++;
    if (b0.q_Animate !== 1'b1 || {b0.proj_x, b0.proj_y} !== {10'd200, 10'd470} || b0.t_air !== 8'd0) begin
      n_fail++; $display("FAIL anim_idle got qA=%b (%0d,%0d) t=%0d want 1 (200,470) 0",
                         b0.q_Animate, b0.proj_x, b0.proj_y, b0.t_air);
    end
    ticks0(30);
    n_tests++;
    if ({b0.proj_x, b0.proj_y} !== {10'd650, 10'd455} || b0.t_air !== 8'd30 || b0.hit !== 1'b0 || b0.q_Animate !== 1'b1) begin
      n_fail++; $display("FAIL p0_tick30 got (%0d,%0d) t=%0d h=%b qA=%b want (650,455) 30 0 1",
                         b0.proj_x, b0.proj_y, b0.t_air, b0.hit, b0.q_Animate);
    end
    ticks0(1);
    n_tests++;
    if (b0.hit !== 1'b1 || b0.miss !== 1'b0 || {b0.proj_x, b0.proj_y} !== {10'd665, 10'd470}) begin
      n_fail++; $display("FAIL p0_hit got h=%b m=%b (%0d,%0d) want 1 0 (665,470)", b0.hit, b0.miss, b0.proj_x, b0.proj_y);
    end
    n_tests++;
    if (b0.scores !== 8'h01 || b0.player !== 1'b1 || b0.q_Shoot !== 1'b1) begin
      n_fail++; $display("FAIL p0_score got s=%h p=%0d qS=%b want 01 1 1", b0.scores, b0.player, b0.q_Shoot);
    end
    cyc();
    n_tests++;
    if (b0.hit !== 1'b0 || {b0.proj_x, b0.proj_y} !== {10'd735, 10'd470} || b0.t_air !== 8'd0) begin
      n_fail++; $display("FAIL p1_launchpt got h=%b (%0d,%0d) t=%0d want 0 (735,470) 0",
                         b0.hit, b0.proj_x, b0.proj_y, b0.t_air);
    end
  endtask

  task automatic test_hit_p1();
    launch0(4'd15, 4'd15);
    ticks0(31);
    n_tests++;
    if (b0.hit !== 1'b1 || {b0.proj_x, b0.proj_y} !== {10'd270, 10'd470} || b0.scores !== 8'h11 || b0.player !== 1'b0) begin
      n_fail++; $display("FAIL p1_hit got h=%b (%0d,%0d) s=%h p=%0d want 1 (270,470) 11 0",
                         b0.hit, b0.proj_x, b0.proj_y, b0.scores, b0.player);
    end
  endtask

  task automatic test_miss();
    logic [9:0] ytab [0:2];
    ytab[0] = 10'd470; ytab[1] = 10'd471; ytab[2] = 10'd473;
    launch0(4'd5, 4'd0);
    for (int k = 0; k < 3; k++) begin
      ticks0(1);
      n_tests++;
      if (b0.proj_y !== ytab[k] || b0.miss !== 1'b0 || b0.q_Animate !== 1'b1) begin
        n_fail++; $display("FAIL miss_y%0d got y=%0d m=%b qA=%b want y=%0d 0 1", k + 1, b0.proj_y, b0.miss, b0.q_Animate, ytab[k]);
      end
    end
    ticks0(1);
    n_tests++;
    if (b0.miss !== 1'b1 || b0.hit !== 1'b0 || {b0.proj_x, b0.proj_y} !== {10'd220, 10'd476} ||
        b0.scores !== 8'h11 || b0.player !== 1'b1 || b0.q_Shoot !== 1'b1) begin
      n_fail++; $display("FAIL miss_tick4 got m=%b h=%b (%0d,%0d) s=%h p=%0d qS=%b want 1 0 (220,476) 11 1 1",
                         b0.miss, b0.hit, b0.proj_x, b0.proj_y, b0.scores, b0.player, b0.q_Shoot);
    end
  endtask

  task automatic test_win();
    launch0(4'd5, 4'd0); ticks0(4);   // P1 misses
    launch0(4'd15, 4'd15); ticks0(31); // P0 -> 2
    n_tests++;
    if (b0.scores !== 8'h12 || b0.player !== 1'b1 || b0.q_Shoot !== 1'b1) begin
      n_fail++; $display("FAIL win_mid got s=%h p=%0d qS=%b want 12 1 1", b0.scores, b0.player, b0.q_Shoot);
    end
    launch0(4'd5, 4'd0); ticks0(4);
    launch0(4'd15, 4'd15); ticks0(31); // P0 -> 3
    n_tests++;
    if (b0.q_Done !== 1'b1 || b0.winner !== 1'b0 || b0.scores !== 8'h13 || b0.hit !== 1'b1 || b0.player !== 1'b0) begin
      n_fail++; $display("FAIL win_done got qD=%b w=%0d s=%h h=%b p=%0d want 1 0 13 1 0",
                         b0.q_Done, b0.winner, b0.scores, b0.hit, b0.player);
    end
    b0.Fire = 1'b1; b0.frame_tick = 1'b1; b0.Start = 1'b1;
    cyc(); cyc(); cyc();
    b0.Fire = 1'b0; b0.frame_tick = 1'b0; b0.Start = 1'b0;
    n_tests++;
    if (b0.q_Done !== 1'b1 || b0.scores !== 8'h13 || b0.proj_x !== 10'd665 || b0.hit !== 1'b0 || b0.t_air !== 8'd31) begin
      n_fail++; $display("FAIL done_frozen got qD=%b s=%h x=%0d h=%b t=%0d want 1 13 665 0 31",
                         b0.q_Done, b0.scores, b0.proj_x, b0.hit, b0.t_air);
    end
    b0.Ack = 1'b1; cyc(); b0.Ack = 1'b0;
    n_tests++;
    if (b0.q_I !== 1'b1 || b0.scores !== 8'h13) begin
      n_fail++; $display("FAIL ack got qI=%b s=%h want 1 13", b0.q_I, b0.scores);
    end
    start0();
    n_tests++;
    if (b0.q_Shoot !== 1'b1 || b0.scores !== 8'h00 || b0.player !== 1'b0) begin
      n_fail++; $display("FAIL restart got qS=%b s=%h p=%0d want 1 00 0", b0.q_Shoot, b0.scores, b0.player);
    end
  endtask

  task automatic test_tmax();
    int ytab [8];
    ytab = '{466, 463, 461, 460, 460, 461, 463, 466};
    b1.Start = 1'b1; cyc(); b1.Start = 1'b0;
    b1.vX = 4'd0; b1.vY = 4'd4; b1.Fire = 1'b1; cyc(); b1.Fire = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(); b1.frame_tick = 1'b1; cyc(); b1.frame_tick = 1'b0;
      n_tests++;
      if (b1.proj_y !== 10'(ytab[k]) || b1.miss !== (k == 7) || b1.hit !== 1'b0) begin
        n_fail++; $display("FAIL tmax_tick%0d got y=%0d m=%b h=%b want y=%0d m=%b 0",
                           k + 1, b1.proj_y, b1.miss, b1.hit, ytab[k], (k == 7));
      end
    end
    n_tests++;
    if (b1.t_air !== 8'd8 || b1.q_Shoot !== 1'b1 || b1.proj_x !== 10'd200 || b1.player !== 1'b1) begin
      n_fail++; $display("FAIL tmax_end got t=%0d qS=%b x=%0d p=%0d want 8 1 200 1", b1.t_air, b1.q_Shoot, b1.proj_x, b1.player);
    end
  endtask

  task automatic test_async_reset();
    launch0(4'd15, 4'd15); ticks0(31);
    launch0(4'd15, 4'd15); ticks0(3);
    n_tests++;
    if (b0.q_Animate !== 1'b1 || b0.scores !== 8'h01 || b0.player !== 1'b1 || b0.t_air !== 8'd3) begin
      n_fail++; $display("FAIL pre_reset got qA=%b s=%h p=%0d t=%0d want 1 01 1 3", b0.q_Animate, b0.scores, b0.player, b0.t_air);
    end
    #2 Reset_n = 1'b0;
    #1;
    n_tests++;
    if (b0.q_I !== 1'b1 || {b0.proj_x, b0.proj_y} !== {10'd200, 10'd470} ||
        {b0.t_air, b0.scores, b0.player, b0.winner} !== 18'd0) begin
      n_fail++; $display("FAIL async_reset got qI=%b (%0d,%0d) t=%0d s=%h p=%0d w=%0d want 1 (200,470) zeros",
                         b0.q_I, b0.proj_x, b0.proj_y, b0.t_air, b0.scores, b0.player, b0.winner);
    end
    cyc(); Reset_n = 1'b1; cyc();
  endtask

  initial begin
    {b0.Start, b0.Ack, b0.Fire, b0.frame_tick, b0.vX, b0.vY} = '0;
    {b1.Start, b1.Ack, b1.Fire, b1.frame_tick, b1.vX, b1.vY} = '0;
    test_reset();
    test_ignore_in_i();
    test_hit_p0();
    test_hit_p1();
    test_miss();
    test_win();
    test_tmax();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
